// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder and the core's dmem port.
// The request struct lets the core bundle the dmem request port into one signal.
package dmem_responder_pkg;

   localparam int DMEM_WORD_BYTES = 8;
   localparam int DMEM_ADDR_W     = 64;
   localparam int DMEM_DATA_W     = 64;

   typedef enum logic [1:0] {
      DMEM_IDLE,
      DMEM_WAIT,
      DMEM_RESP
   } dmem_state_t;

   typedef struct packed {
      logic [DMEM_ADDR_W-1:0]     addr;
      logic [DMEM_DATA_W-1:0]     wdata;
      logic [DMEM_WORD_BYTES-1:0] wstrb;
      logic                       wen;
   } dmem_req_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous 64-bit word array with per-byte write enables.
// A write cycle leaves rdata untouched; a read cycle (en with no byte enables) registers the word.
module dmem_array
   import dmem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic                       clk,
   input  logic                       en,
   input  logic [DMEM_WORD_BYTES-1:0] we,
   input  logic [IDX_W-1:0]           idx,
   input  logic [DMEM_DATA_W-1:0]     wdata,
   output logic [DMEM_DATA_W-1:0]     rdata
);

   logic [DMEM_DATA_W-1:0] mem [DEPTH_WORDS];

   // NOTE: the array and its read register have no reset so they map onto block RAM.
   always_ff @(posedge clk) begin
      if (en) begin
         if (|we) begin
            for (int b = 0; b < DMEM_WORD_BYTES; b++) begin
               if (we[b]) begin
                  mem[idx][8*b +: 8] <= wdata[8*b +: 8];
               end
            end
         end else begin
            rdata <= mem[idx];
         end
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, fixed programmable latency,
// response held until the requester accepts it.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          LATENCY     = 2,
   parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_8000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [63:0] req_addr_i,
   input  logic        req_wen_i,
   input  logic [63:0] req_wdata_i,
   input  logic [7:0]  req_wstrb_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [63:0] rsp_rdata_o,
   output logic        rsp_err_o
);

   localparam int          IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [63:0] SPAN  = 64'(DEPTH_WORDS) * 64'(DMEM_WORD_BYTES);
   localparam logic [3:0]  LAT   = 4'(LATENCY);

   dmem_state_t state, state_n;
   logic [3:0]  cnt, cnt_n;
   logic        load_q;
   logic        err_q;

   dmem_req_t        req;
   logic             accept;
   logic             fault;
   logic [63:0]      offset;
   logic [IDX_W-1:0] idx;
   logic [7:0]       arr_we;
   logic             arr_en;
   logic [63:0]      arr_rdata;

   assign req = '{addr: req_addr_i, wdata: req_wdata_i, wstrb: req_wstrb_i, wen: req_wen_i};

   assign accept = req_valid_i && (state == DMEM_IDLE);
   assign offset = req.addr - BASE_ADDR;
   // The below-base test keeps wrapped offsets from aliasing onto low words.
   assign fault  = (req.addr[2:0] != 3'b000) || (req.addr < BASE_ADDR) || (offset >= SPAN);
   assign idx    = offset[IDX_W+2:3];

   assign arr_en = accept && !fault;
   assign arr_we = (arr_en && req.wen) ? req.wstrb : 8'h00;

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_array (
      .clk   (clk),
      .en    (arr_en),
      .we    (arr_we),
      .idx   (idx),
      .wdata (req.wdata),
      .rdata (arr_rdata)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= DMEM_IDLE;
         cnt    <= 4'd0;
         load_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (accept) begin
            load_q <= !req.wen;
            err_q  <= fault;
         end else if (state == DMEM_RESP && rsp_ready_i) begin
            load_q <= 1'b0;
            err_q  <= 1'b0;
         end
      end
   end

   // NOTE: defaults first so no path through the case leaves a variable unassigned (no latches).
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      unique case (state)
         DMEM_IDLE: begin
            if (accept) begin
               if (LAT != 4'd0) begin
                  state_n = DMEM_WAIT;
                  cnt_n   = LAT;
               end else begin
                  state_n = DMEM_RESP;
               end
            end
         end
         DMEM_WAIT: begin
            if (cnt <= 4'd1) begin
               state_n = DMEM_RESP;
               cnt_n   = 4'd0;
            end else begin
               cnt_n = cnt - 4'd1;
            end
         end
         DMEM_RESP: begin
            if (rsp_ready_i) begin
               state_n = DMEM_IDLE;
            end
         end
         default: begin
            state_n = DMEM_IDLE;
            cnt_n   = 4'd0;
         end
      endcase
   end

   // The array read register only changes at an accept edge, so the response stays stable while held.
   assign req_ready_o = (state == DMEM_IDLE);
   assign rsp_valid_o = (state == DMEM_RESP);
   assign rsp_err_o   = rsp_valid_o && err_q;
   assign rsp_rdata_o = (rsp_valid_o && load_q && !err_q) ? arr_rdata : 64'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance driven from a vector table
// and hand sequences, plus a LATENCY=0 instance for back-to-back throughput.
module tb_dmem_responder;

   localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
   localparam int          DEPTH = 64;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // LATENCY=2 instance
   logic        req_valid, req_ready, req_wen, rsp_valid, rsp_ready, rsp_err;
   logic [63:0] req_addr, req_wdata, rsp_rdata;
   logic [7:0]  req_wstrb;

   // LATENCY=0 instance, response side always ready
   logic        z_req_valid, z_req_ready, z_req_wen, z_rsp_valid, z_rsp_err;
   logic        z_rsp_ready = 1'b1;
   logic [63:0] z_req_addr, z_req_wdata, z_rsp_rdata;
   logic [7:0]  z_req_wstrb;

   int checks = 0;
   int errors = 0;

   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2), .BASE_ADDR(BASE)) u_dut (
      .clk (clk), .rst_n (rst_n),
      .req_valid_i (req_valid), .req_ready_o (req_ready), .req_addr_i (req_addr),
      .req_wen_i (req_wen), .req_wdata_i (req_wdata), .req_wstrb_i (req_wstrb),
      .rsp_valid_o (rsp_valid), .rsp_ready_i (rsp_ready), .rsp_rdata_o (rsp_rdata),
      .rsp_err_o (rsp_err)
   );

   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0), .BASE_ADDR(BASE)) u_dut0 (
      .clk (clk), .rst_n (rst_n),
      .req_valid_i (z_req_valid), .req_ready_o (z_req_ready), .req_addr_i (z_req_addr),
      .req_wen_i (z_req_wen), .req_wdata_i (z_req_wdata), .req_wstrb_i (z_req_wstrb),
      .rsp_valid_o (z_rsp_valid), .rsp_ready_i (z_rsp_ready), .rsp_rdata_o (z_rsp_rdata),
      .rsp_err_o (z_rsp_err)
   );

   typedef struct {
      logic        wen;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [7:0]  strb;
      logic [63:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Present one request to the LATENCY=2 instance, then scramble the inputs after the accept edge.
   task automatic a_issue(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [7:0] strb);
      @(negedge clk);
      req_valid = 1'b1;
      req_wen   = wen;
      req_addr  = addr;
      req_wdata = wdata;
      req_wstrb = strb;
      check("ready_before_accept", 64'(req_ready), 64'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_wen   = ~wen;
      req_addr  = ~addr;
      req_wdata = ~wdata;
      req_wstrb = ~strb;
   endtask

   // Count edges after the accept edge until rsp_valid is seen, then complete the handshake.
   task automatic a_wait(output logic [63:0] rdata, output logic err, output int lat);
      lat = 0;
      while (lat < 40) begin
         @(negedge clk);
         if (rsp_valid) break;
         lat++;
      end
      rdata = rsp_rdata;
      err   = rsp_err;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
   endtask

   task automatic z_txn(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [7:0] strb, output logic [63:0] rdata, output logic err,
                        output int lat);
      @(negedge clk);
      z_req_valid = 1'b1;
      z_req_wen   = wen;
      z_req_addr  = addr;
      z_req_wdata = wdata;
      z_req_wstrb = strb;
      @(posedge clk);
      #1;
      z_req_valid = 1'b0;
      lat = 0;
      while (lat < 40) begin
         @(negedge clk);
         if (z_rsp_valid) break;
         lat++;
      end
      rdata = z_rsp_rdata;
      err   = z_rsp_err;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      logic [63:0] rd;
      logic        er;
      int          lat;
      logic [63:0] held;

      //           wen   addr           wdata                   strb   exp_rdata               err
      vecs[0]  = '{1'b1, BASE + 64'h10,  64'h1122_3344_5566_7788, 8'hFF, 64'h0,                  1'b0};
      vecs[1]  = '{1'b0, BASE + 64'h10,  64'h5A5A_5A5A_5A5A_5A5A, 8'h00, 64'h1122_3344_5566_7788, 1'b0};
      vecs[2]  = '{1'b1, BASE + 64'h10,  64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 64'h0,                  1'b0};
      vecs[3]  = '{1'b0, BASE + 64'h10,  64'h0,                  8'hFF, 64'h1122_3344_AAAA_AAAA, 1'b0};
      vecs[4]  = '{1'b0, BASE + 64'h13,  64'h0,                  8'h00, 64'h0,                  1'b1};
      vecs[5]  = '{1'b1, BASE,           64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 64'h0,                  1'b0};
      vecs[6]  = '{1'b1, BASE + 64'h200, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'h0,                  1'b1};
      vecs[7]  = '{1'b0, BASE,           64'h0,                  8'h00, 64'hDEAD_BEEF_CAFE_F00D, 1'b0};
      vecs[8]  = '{1'b0, BASE - 64'h8,   64'h0,                  8'h00, 64'h0,                  1'b1};
      vecs[9]  = '{1'b1, BASE + 64'h10,  64'h0123_4567_89AB_CDEF, 8'h00, 64'h0,                  1'b0};
      vecs[10] = '{1'b0, BASE + 64'h10,  64'h0,                  8'h00, 64'h1122_3344_AAAA_AAAA, 1'b0};
      vecs[11] = '{1'b1, BASE + 64'h1F8, 64'h0102_0304_0506_0708, 8'hFF, 64'h0,                  1'b0};
      vecs[12] = '{1'b1, BASE + 64'h1F8, 64'hFFEE_DDCC_BBAA_9988, 8'h81, 64'h0,                  1'b0};
      vecs[13] = '{1'b0, BASE + 64'h1F8, 64'h0,                  8'hFF, 64'hFF02_0304_0506_0788, 1'b0};

      req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
      rsp_ready = 1'b0;
      z_req_valid = 1'b0; z_req_wen = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_req_wstrb = '0;

      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_req_ready",   64'(req_ready), 64'd1);
      check("rst_rsp_valid",   64'(rsp_valid), 64'd0);
      check("rst_rsp_rdata",   rsp_rdata,      64'd0);
      check("rst_rsp_err",     64'(rsp_err),   64'd0);
      check("rst_z_req_ready", 64'(z_req_ready), 64'd1);
      check("rst_z_rsp_valid", 64'(z_rsp_valid), 64'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 14; i++) begin
         a_issue(vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].strb);
         a_wait(rd, er, lat);
         check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
         check($sformatf("vec%0d_err", i), 64'(er), 64'(vecs[i].exp_err));
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'd2);
      end

      // Held response with a competing request present the whole time.
      a_issue(1'b0, BASE + 64'h10, 64'h0, 8'h00);
      lat = 0;
      while (lat < 40 && !rsp_valid) begin
         @(negedge clk);
         lat++;
      end
      check("hold_valid_seen", 64'(rsp_valid), 64'd1);
      req_valid = 1'b1;
      req_wen   = 1'b0;
      req_addr  = BASE;
      held      = rsp_rdata;
      for (int k = 0; k < 5; k++) begin
         check($sformatf("hold%0d_valid", k), 64'(rsp_valid), 64'd1);
         check($sformatf("hold%0d_rdata", k), rsp_rdata, 64'h1122_3344_AAAA_AAAA);
         check($sformatf("hold%0d_stable", k), rsp_rdata, held);
         check($sformatf("hold%0d_req_ready", k), 64'(req_ready), 64'd0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      check("release_rsp_valid", 64'(rsp_valid), 64'd0);
      check("release_req_ready", 64'(req_ready), 64'd1);
      rsp_ready = 1'b0;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      a_wait(rd, er, lat);
      check("queued_load_rdata", rd, 64'hDEAD_BEEF_CAFE_F00D);
      check("queued_load_latency", 64'(lat), 64'd2);

      // Reset while waiting after a store accept.
      a_issue(1'b1, BASE + 64'h20, 64'h5555_6666_7777_8888, 8'hFF);
      @(negedge clk);
      check("wait_req_ready", 64'(req_ready), 64'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("midrst_req_ready", 64'(req_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      a_issue(1'b0, BASE + 64'h20, 64'h0, 8'h00);
      a_wait(rd, er, lat);
      check("postrst_rdata", rd, 64'h5555_6666_7777_8888);
      check("postrst_err", 64'(er), 64'd0);

      // Zero-latency instance: fill two words, then back-to-back loads.
      z_txn(1'b1, BASE,          64'h0F0F_0F0F_0F0F_0F0F, 8'hFF, rd, er, lat);
      check("z_store0_latency", 64'(lat), 64'd0);
      z_txn(1'b1, BASE + 64'h8,  64'h1234_5678_9ABC_DEF0, 8'hFF, rd, er, lat);
      check("z_store1_err", 64'(er), 64'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("z%0d_ready", i), 64'(z_req_ready), 64'd1);
         z_req_valid = 1'b1;
         z_req_wen   = 1'b0;
         z_req_addr  = BASE + 64'(8 * (i % 2));
         @(negedge clk);
         check($sformatf("z%0d_valid", i), 64'(z_rsp_valid), 64'd1);
         check($sformatf("z%0d_rdata", i), z_rsp_rdata,
               (i % 2 == 0) ? 64'h0F0F_0F0F_0F0F_0F0F : 64'h1234_5678_9ABC_DEF0);
         check($sformatf("z%0d_busy", i), 64'(z_req_ready), 64'd0);
      end
      z_req_valid = 1'b0;
      @(negedge clk);
      check("z_idle_after", 64'(z_rsp_valid), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
